// File: rtl/spi_host_master.sv
// Host-side SPI master: drives csb/sclk/sdi frames of a 16-bit instruction followed by 1..4 data
// bytes, MSB first, and captures sdo into rd_data during the data bits of read frames.
module spi_host_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_IDLE  = 4
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        start,
  input  logic        rd_wr,
  input  logic [1:0]  w1w0,
  input  logic [12:0] addr,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd_data,
  output logic        csb,
  output logic        sclk,
  output logic        sdi,
  input  logic        sdo
);

  localparam int unsigned DivW    = $clog2(CLK_DIV);
  localparam int unsigned WaitMax = (CS_SETUP > CS_HOLD) ?
                                    ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE) :
                                    ((CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE);
  localparam int unsigned WaitW   = $clog2(WaitMax + 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [5:0]        bit_q, bit_d;
  logic [47:0]       shift_q, shift_d;
  logic              rd_q, rd_d;
  logic [1:0]        w1w0_q, w1w0_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              csb_q, csb_d;
  logic              sclk_q, sclk_d;
  logic              sdi_q, sdi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [5:0]        last_bit;
  logic [31:0]       data_left;

  assign last_bit = 6'd23 + {1'b0, w1w0_q, 3'b000};

  // Left-align the N data bytes so they follow the instruction directly.
  always_comb begin
    data_left = wr_data;
    case (w1w0)
      2'd0:    data_left = {wr_data[7:0], 24'h0};
      2'd1:    data_left = {wr_data[15:0], 16'h0};
      2'd2:    data_left = {wr_data[23:0], 8'h0};
      default: data_left = wr_data;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    wait_d    = wait_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    rd_d      = rd_q;
    w1w0_d    = w1w0_q;
    rd_data_d = rd_data_q;
    csb_d     = csb_q;
    sclk_d    = sclk_q;
    sdi_d     = sdi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StSetup;
          shift_d   = {rd_wr, w1w0, addr, data_left};
          rd_d      = rd_wr;
          w1w0_d    = w1w0;
          rd_data_d = '0;
          busy_d    = 1'b1;
          csb_d     = 1'b0;
          sdi_d     = rd_wr;
          wait_d    = '0;
          bit_d     = '0;
        end
      end
      StSetup: begin
        if (wait_q == WaitW'(CS_SETUP - 1)) begin
          state_d = StShift;
          div_d   = '0;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StShift: begin
        if (div_q == DivW'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            if (rd_q && (bit_q >= 6'd16)) begin
              rd_data_d = {rd_data_q[30:0], sdo};
            end
          end else begin
            sclk_d = 1'b0;
            if (bit_q == last_bit) begin
              state_d = StHold;
              sdi_d   = 1'b0;
            end else begin
              bit_d   = bit_q + 6'd1;
              shift_d = {shift_q[46:0], shift_q[47]};
              sdi_d   = shift_q[46];
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StHold: begin
        if (wait_q == WaitW'(CS_HOLD - 1)) begin
          state_d = StGap;
          csb_d   = 1'b1;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StGap: begin
        // The done cycle is still in StGap so a start presented alongside done is ignored.
        if (done_q) begin
          state_d = StIdle;
        end else if (wait_q == WaitW'(CS_IDLE - 1)) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q   <= StIdle;
      div_q     <= '0;
      wait_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rd_q      <= 1'b0;
      w1w0_q    <= '0;
      rd_data_q <= '0;
      csb_q     <= 1'b1;
      sclk_q    <= 1'b0;
      sdi_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      wait_q    <= wait_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rd_q      <= rd_d;
      w1w0_q    <= w1w0_d;
      rd_data_q <= rd_data_d;
      csb_q     <= csb_d;
      sclk_q    <= sclk_d;
      sdi_q     <= sdi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_data = rd_data_q;
  assign csb     = csb_q;
  assign sclk    = sclk_q;
  assign sdi     = sdi_q;

endmodule

// File: tb/tb_spi_host_master.sv
// Scoreboard bench for spi_host_master: two instances (CLK_DIV 4 and 2), a bit-list reference
// model, an SPI slave model on sdo, and a monitor that checks every frame at its done pulse.
`timescale 1ns/1ps
module tb_spi_host_master;

  localparam int unsigned CSS = 2;
  localparam int unsigned CSH = 2;
  localparam int unsigned CSI = 4;
  localparam int unsigned CD0 = 4;
  localparam int unsigned CD1 = 2;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]        start_v = '0, rd_wr_v = '0;
  logic [1:0][1:0]   w1w0_v = '0;
  logic [1:0][12:0]  addr_v = '0;
  logic [1:0][31:0]  wr_data_v = '0;
  logic [1:0]        busy_v, done_v, csb_v, sclk_v, sdi_v, sdo_v;
  logic [1:0][31:0]  rd_data_v;
  logic [1:0]        sdo_low = '0;
  logic [1:0][31:0]  slave_word = '0;
  logic [1:0]        slave_float = '1;

  // Open-drain line: the slave only ever pulls low, the board pull-up supplies the 1.
  assign sdo_v = ~sdo_low;

  spi_host_master #(.CLK_DIV(CD0), .CS_SETUP(CSS), .CS_HOLD(CSH), .CS_IDLE(CSI)) u0 (
    .clk(clk), .resetb(resetb), .start(start_v[0]), .rd_wr(rd_wr_v[0]), .w1w0(w1w0_v[0]),
    .addr(addr_v[0]), .wr_data(wr_data_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .rd_data(rd_data_v[0]), .csb(csb_v[0]), .sclk(sclk_v[0]), .sdi(sdi_v[0]), .sdo(sdo_v[0])
  );

  spi_host_master #(.CLK_DIV(CD1), .CS_SETUP(CSS), .CS_HOLD(CSH), .CS_IDLE(CSI)) u1 (
    .clk(clk), .resetb(resetb), .start(start_v[1]), .rd_wr(rd_wr_v[1]), .w1w0(w1w0_v[1]),
    .addr(addr_v[1]), .wr_data(wr_data_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .rd_data(rd_data_v[1]), .csb(csb_v[1]), .sclk(sclk_v[1]), .sdi(sdi_v[1]), .sdo(sdo_v[1])
  );

  typedef struct {
    longint      fall_cyc;
    longint      rise_cyc;
    longint      done_cyc;
    logic [47:0] frame;
    int          nbits;
    logic [31:0] rd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // Reference model: frame as an ordered list of bits plus absolute cycle stamps.
  function automatic exp_t model(input int d, input logic rw, input logic [1:0] w,
                                 input logic [12:0] a, input logic [31:0] wd,
                                 input logic [31:0] sval, input bit sfloat, input longint t0);
    exp_t e;
    bit bits[$];
    int nbytes = int'(w) + 1;
    longint cd = (d == 0) ? longint'(CD0) : longint'(CD1);
    logic [31:0] m = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
    bits.push_back(rw);
    bits.push_back(w[1]);
    bits.push_back(w[0]);
    for (int i = 12; i >= 0; i--) bits.push_back(a[i]);
    for (int b = nbytes - 1; b >= 0; b--)
      for (int i = 7; i >= 0; i--) bits.push_back(wd[8 * b + i]);
    e.nbits = bits.size();
    e.frame = '0;
    foreach (bits[i]) e.frame = {e.frame[46:0], bits[i]};
    e.rd = rw ? (sfloat ? m : (sval & m)) : 32'h0;
    e.fall_cyc = t0 + 1;
    e.rise_cyc = t0 + 1 + CSS + 2 * cd * e.nbits + CSH;
    e.done_cyc = e.rise_cyc + CSI;
    return e;
  endfunction

  // Call just after a negedge: presents start for one cycle and records the expectation.
  task automatic issue(input int d, input logic rw, input logic [1:0] w, input logic [12:0] a,
                       input logic [31:0] wd, input logic [31:0] sval, input bit sfloat);
    exp_t e;
    rd_wr_v[d]     = rw;
    w1w0_v[d]      = w;
    addr_v[d]      = a;
    wr_data_v[d]   = wd;
    slave_word[d]  = sval << (8 * (3 - int'(w)));
    slave_float[d] = sfloat | ~rw;
    start_v[d]     = 1'b1;
    e = model(d, rw, w, a, wd, sval, sfloat | ~rw, cyc);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
    @(negedge clk);
    start_v[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int n = 0;
    while (qsize(d) != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (qsize(d) != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL u%0d.timeout: %0d frames still pending, required 0", d, qsize(d));
      if (d == 0) q0.delete();
      else q1.delete();
    end
    repeat (8) @(negedge clk);
  endtask

  int          nb[2];
  logic [47:0] col[2];
  int          run[2];
  bit          bad_half[2];
  bit          have_rise[2];
  longint      fall_c[2];
  longint      rise_c[2];
  logic        p_sclk[2];
  logic        p_csb[2];
  logic        p_done[2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int cd;
      exp_t e;
      cd = (d == 0) ? int'(CD0) : int'(CD1);
      if (!resetb) begin
        nb[d] = 0; col[d] = '0; run[d] = 0; bad_half[d] = 0; have_rise[d] = 0;
        p_sclk[d] = 1'b0; p_csb[d] = 1'b1; p_done[d] = 1'b0; sdo_low[d] = 1'b0;
      end else begin
        if (p_csb[d] && !csb_v[d]) begin
          if (have_rise[d])
            check($sformatf("u%0d.csb_idle_ge_%0d", d, CSI),
                  64'((cyc - rise_c[d]) >= longint'(CSI)), 64'(1));
          fall_c[d] = cyc; nb[d] = 0; col[d] = '0; bad_half[d] = 0; run[d] = 1;
          sdo_low[d] = 1'b0;
        end else if (!p_csb[d] && csb_v[d]) begin
          rise_c[d] = cyc; have_rise[d] = 1; sdo_low[d] = 1'b0;
        end else if (!csb_v[d]) begin
          if (!p_sclk[d] && sclk_v[d]) begin
            if (nb[d] > 0 && run[d] != cd) bad_half[d] = 1;
            nb[d]++;
            col[d] = {col[d][46:0], sdi_v[d]};
            run[d] = 1;
          end else if (p_sclk[d] && !sclk_v[d]) begin
            if (run[d] != cd) bad_half[d] = 1;
            run[d] = 1;
            if (nb[d] >= 16 && (nb[d] - 16) < 32)
              sdo_low[d] = !slave_float[d] && !slave_word[d][31 - (nb[d] - 16)];
            else
              sdo_low[d] = 1'b0;
          end else begin
            run[d]++;
          end
        end
        if (done_v[d]) begin
          check($sformatf("u%0d.done_one_cycle", d), 64'(p_done[d]), 64'(0));
          check($sformatf("u%0d.busy_at_done", d), 64'(busy_v[d]), 64'(0));
          if (qsize(d) == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL u%0d.unexpected_done: got done at cycle %0d, expected none", d, cyc);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("u%0d.done_cyc", d), 64'(cyc), 64'(e.done_cyc));
            check($sformatf("u%0d.csb_fall_cyc", d), 64'(fall_c[d]), 64'(e.fall_cyc));
            check($sformatf("u%0d.csb_rise_cyc", d), 64'(rise_c[d]), 64'(e.rise_cyc));
            check($sformatf("u%0d.nbits", d), 64'(nb[d]), 64'(e.nbits));
            check($sformatf("u%0d.frame", d), 64'(col[d]), 64'(e.frame));
            check($sformatf("u%0d.rd_data", d), 64'(rd_data_v[d]), 64'(e.rd));
            check($sformatf("u%0d.sclk_half_eq_%0d", d, cd), 64'(bad_half[d]), 64'(0));
          end
        end
        p_sclk[d] = sclk_v[d];
        p_csb[d]  = csb_v[d];
        p_done[d] = done_v[d];
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst.csb", 64'(csb_v[0]), 64'(1));
    check("rst.sclk", 64'(sclk_v[0]), 64'(0));
    check("rst.sdi", 64'(sdi_v[0]), 64'(0));
    check("rst.busy", 64'(busy_v[0]), 64'(0));
    check("rst.done", 64'(done_v[0]), 64'(0));
    check("rst.rd_data", 64'(rd_data_v[0]), 64'(0));
    resetb = 1'b1;
    repeat (3) @(negedge clk);

    // 1-byte write, then 4-byte read of 0xDEADBEEF, then 2-byte read with sdo floating.
    issue(0, 1'b0, 2'd0, 13'h0014, 32'h0000_00A5, 32'h0, 1'b1);
    drain(0);
    issue(0, 1'b1, 2'd3, 13'h1FFF, $urandom, 32'hDEAD_BEEF, 1'b0);
    drain(0);
    check("u0.rd_hold", 64'(rd_data_v[0]), 64'(32'hDEAD_BEEF));
    issue(0, 1'b1, 2'd1, 13'(($urandom)), $urandom, $urandom, 1'b1);
    drain(0);

    // start pulsed with different inputs while busy must be ignored.
    issue(0, 1'b0, 2'd2, 13'h0ABC, 32'h0012_3456, 32'h0, 1'b1);
    repeat (60) @(negedge clk);
    check("u0.busy_mid", 64'(busy_v[0]), 64'(1));
    rd_wr_v[0] = 1'b1; w1w0_v[0] = 2'd3; addr_v[0] = 13'h1555; wr_data_v[0] = 32'hFFFF_FFFF;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    drain(0);

    // Reset during the 20th sclk pulse of a write aborts without done.
    @(negedge clk);
    issue(0, 1'b0, 2'd3, 13'h0F0F, 32'hCAFE_F00D, 32'h0, 1'b1);
    n = 0;
    while (nb[0] < 20 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("u0.reach_20th_sclk", 64'(nb[0] >= 20), 64'(1));
    #2 resetb = 1'b0;
    #1;
    check("abort.csb", 64'(csb_v[0]), 64'(1));
    check("abort.sclk", 64'(sclk_v[0]), 64'(0));
    check("abort.busy", 64'(busy_v[0]), 64'(0));
    check("abort.done", 64'(done_v[0]), 64'(0));
    q0.delete();
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    repeat (20) @(negedge clk);
    issue(0, 1'b0, 2'd1, 13'h0123, 32'h0000_5AC3, 32'h0, 1'b1);
    drain(0);

    // CLK_DIV=2: back-to-back writes, second start held through the done cycle.
    @(negedge clk);
    issue(1, 1'b0, 2'(($urandom)), 13'(($urandom)), $urandom, 32'h0, 1'b1);
    n = 0;
    while (done_v[1] !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("u1.first_done_seen", 64'(done_v[1]), 64'(1));
    rd_wr_v[1] = 1'b0; w1w0_v[1] = 2'd1; addr_v[1] = 13'h1234; wr_data_v[1] = 32'h0000_9E37;
    start_v[1] = 1'b1;
    @(negedge clk);
    issue(1, 1'b0, 2'd1, 13'h1234, 32'h0000_9E37, 32'h0, 1'b1);
    drain(1);

    for (int i = 0; i < 10; i++) begin
      int d;
      d = int'($urandom_range(0, 1));
      @(negedge clk);
      issue(d, 1'($urandom), 2'($urandom), 13'($urandom), $urandom, $urandom,
            ($urandom_range(0, 3) == 0));
      drain(d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
